// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the control sequencer: state encoding, opcode constants,
// opcode class decode and the strobe bundle.
package ctrl_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH0 = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_FETCH2 = 4'd3,
        ST_EX3    = 4'd4,
        ST_EX4    = 4'd5,
        ST_EX5    = 4'd6,
        ST_EX6    = 4'd7,
        ST_HALT   = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CLS_BINARY = 2'd0,
        CLS_UNARY  = 2'd1,
        CLS_LONG   = 2'd2,
        CLS_HALT   = 2'd3
    } op_class_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic zhigh_in;
        logic zlow_out;
        logic zhigh_out;
        logic lo_in;
        logic hi_in;
    } strobe_t;

    function automatic op_class_e op_class(input logic [OPC_W-1:0] opc);
        op_class_e cls;
        case (opc)
            OPC_NEG, OPC_NOT: cls = CLS_UNARY;
            OPC_MUL, OPC_DIV: cls = CLS_LONG;
            OPC_HALT:         cls = CLS_HALT;
            default:          cls = CLS_BINARY;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Bus between the control sequencer (master) and the datapath (slave).
interface ctrl_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5,
    parameter int WORD     = 32
);
    // Run is a level enable; mem_ready is a one-sided completion flag from
    // memory, sampled only while the sequencer waits in FETCH1.
    logic                Run;
    logic                mem_ready;
    logic [WORD-1:0]     IR;

    logic                PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic                Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic [OP_W-1:0]     operation;
    logic                busy;
    logic                done;
    logic [3:0]          state;

    modport master (
        input  Run, mem_ready, IR,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
        output Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        output reg_in, reg_out, operation, busy, done, state
    );

    modport slave (
        output Run, mem_ready, IR,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
        input  Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
        input  reg_in, reg_out, operation, busy, done, state
    );

endinterface

// File: rtl/ctrl_sequencer_ir_decode.sv
// Combinational instruction field decode: opcode, opcode class and one-hot
// register selects for Ra, Rb, Rc.
module ir_decode
    import ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5
) (
    input  logic [OP_W+3*$clog2(NUM_REGS)-1:0] fields,
    output logic [OP_W-1:0]                    opcode,
    output op_class_e                          op_cls,
    output logic [NUM_REGS-1:0]                ra_oh,
    output logic [NUM_REGS-1:0]                rb_oh,
    output logic [NUM_REGS-1:0]                rc_oh
);

    localparam int RW = $clog2(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [RW-1:0] ra, rb, rc;

    assign opcode = fields[OP_W+3*RW-1 -: OP_W];
    assign ra     = fields[3*RW-1 -: RW];
    assign rb     = fields[2*RW-1 -: RW];
    assign rc     = fields[RW-1:0];

    assign op_cls = op_class(OPC_W'(opcode));
    assign ra_oh  = ONE << ra;
    assign rb_oh  = ONE << rb;
    assign rc_oh  = ONE << rc;

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch / execute FSM driving the datapath
// strobes. Outputs decode the registered state (register selects use IR).
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5,
    parameter int WORD     = 32
) (
    input  logic             Clock,
    input  logic             clear,
    ctrl_sequencer_if.master bus
);

    localparam int FIELD_W = OP_W + 3 * $clog2(NUM_REGS);

    state_e              state_q;
    logic                fetch1_first;
    logic [OP_W-1:0]     opcode;
    op_class_e           op_cls;
    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;

    strobe_t             stb;
    logic [NUM_REGS-1:0] reg_in_d, reg_out_d;
    logic [OP_W-1:0]     op_d;
    logic                done_d;

    ir_decode #(
        .NUM_REGS (NUM_REGS),
        .OP_W     (OP_W)
    ) u_ir_decode (
        .fields (bus.IR[WORD-1 -: FIELD_W]),
        .opcode (opcode),
        .op_cls (op_cls),
        .ra_oh  (ra_oh),
        .rb_oh  (rb_oh),
        .rc_oh  (rc_oh)
    );

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            fetch1_first <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus.Run) state_q <= ST_FETCH0;
                ST_FETCH0: begin
                    state_q      <= ST_FETCH1;
                    fetch1_first <= 1'b1;
                end
                ST_FETCH1: begin
                    fetch1_first <= 1'b0;
                    if (bus.mem_ready) state_q <= ST_FETCH2;
                end
                ST_FETCH2: state_q <= ST_EX3;
                ST_EX3:    state_q <= (op_cls == CLS_HALT) ? ST_HALT : ST_EX4;
                ST_EX4:    state_q <= ST_EX5;
                ST_EX5: begin
                    if (op_cls == CLS_LONG) state_q <= ST_EX6;
                    else                    state_q <= bus.Run ? ST_FETCH0 : ST_IDLE;
                end
                ST_EX6:    state_q <= bus.Run ? ST_FETCH0 : ST_IDLE;
                ST_HALT:   state_q <= ST_HALT;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // IR is loaded at the end of FETCH2, so register selects are valid from EX3.
    always_comb begin
        stb       = '0;
        reg_in_d  = '0;
        reg_out_d = '0;
        op_d      = '0;
        done_d    = 1'b0;
        case (state_q)
            ST_FETCH0: begin
                stb.pc_out  = 1'b1;
                stb.mar_in  = 1'b1;
                stb.inc_pc  = 1'b1;
                stb.zlow_in = 1'b1;
            end
            ST_FETCH1: begin
                stb.zlow_out = 1'b1;
                stb.pc_in    = fetch1_first;
                stb.read     = 1'b1;
                stb.mdr_in   = 1'b1;
            end
            ST_FETCH2: begin
                stb.mdr_out = 1'b1;
                stb.ir_in   = 1'b1;
            end
            ST_EX3: begin
                if (op_cls == CLS_BINARY || op_cls == CLS_LONG) begin
                    reg_out_d = rb_oh;
                    stb.y_in  = 1'b1;
                end
            end
            ST_EX4: begin
                reg_out_d    = (op_cls == CLS_UNARY) ? rb_oh : rc_oh;
                op_d         = opcode;
                stb.zlow_in  = 1'b1;
                stb.zhigh_in = 1'b1;
            end
            ST_EX5: begin
                stb.zlow_out = 1'b1;
                if (op_cls == CLS_LONG) begin
                    stb.lo_in = 1'b1;
                end else begin
                    reg_in_d = ra_oh;
                    done_d   = 1'b1;
                end
            end
            ST_EX6: begin
                stb.zhigh_out = 1'b1;
                stb.hi_in     = 1'b1;
                done_d        = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCout     = stb.pc_out;
    assign bus.MARin     = stb.mar_in;
    assign bus.IncPC     = stb.inc_pc;
    assign bus.PCin      = stb.pc_in;
    assign bus.Read      = stb.read;
    assign bus.MDRin     = stb.mdr_in;
    assign bus.MDRout    = stb.mdr_out;
    assign bus.IRin      = stb.ir_in;
    assign bus.Yin       = stb.y_in;
    assign bus.Zlowin    = stb.zlow_in;
    assign bus.Zhighin   = stb.zhigh_in;
    assign bus.Zlowout   = stb.zlow_out;
    assign bus.Zhighout  = stb.zhigh_out;
    assign bus.LOin      = stb.lo_in;
    assign bus.HIin      = stb.hi_in;
    assign bus.reg_in    = reg_in_d;
    assign bus.reg_out   = reg_out_d;
    assign bus.operation = op_d;
    assign bus.done      = done_d;
    assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-cycle expected output vectors
// are queued when an instruction is issued and popped as the DUT runs.
module tb_ctrl_sequencer;

    localparam int OBS_W = 58;

    localparam logic [14:0] S_PCOUT    = 15'h4000;
    localparam logic [14:0] S_MARIN    = 15'h2000;
    localparam logic [14:0] S_INCPC    = 15'h1000;
    localparam logic [14:0] S_PCIN     = 15'h0800;
    localparam logic [14:0] S_READ     = 15'h0400;
    localparam logic [14:0] S_MDRIN    = 15'h0200;
    localparam logic [14:0] S_MDROUT   = 15'h0100;
    localparam logic [14:0] S_IRIN     = 15'h0080;
    localparam logic [14:0] S_YIN      = 15'h0040;
    localparam logic [14:0] S_ZLOWIN   = 15'h0020;
    localparam logic [14:0] S_ZHIGHIN  = 15'h0010;
    localparam logic [14:0] S_ZLOWOUT  = 15'h0008;
    localparam logic [14:0] S_ZHIGHOUT = 15'h0004;
    localparam logic [14:0] S_LOIN     = 15'h0002;
    localparam logic [14:0] S_HIIN     = 15'h0001;

    logic Clock;
    logic clear;

    logic [OBS_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    ctrl_sequencer_if #(.NUM_REGS(16), .OP_W(5), .WORD(32)) bif ();

    ctrl_sequencer #(.NUM_REGS(16), .OP_W(5), .WORD(32)) dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bif)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: time limit reached, got no finish, required finish before 100000 ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- model helpers ----------------
    function automatic logic [OBS_W-1:0] mk(input logic [3:0] st, input logic [14:0] s,
                                            input logic [15:0] ro, input logic [15:0] ri,
                                            input logic [4:0] op, input logic dn);
        logic bz;
        bz = (st != 4'd0) && (st != 4'd8);
        return {st, bz, dn, op, ri, ro, s};
    endfunction

    function automatic logic [OBS_W-1:0] sample();
        return {bif.state, bif.busy, bif.done, bif.operation, bif.reg_in, bif.reg_out,
                bif.PCout, bif.MARin, bif.IncPC, bif.PCin, bif.Read, bif.MDRin,
                bif.MDRout, bif.IRin, bif.Yin, bif.Zlowin, bif.Zhighin,
                bif.Zlowout, bif.Zhighout, bif.LOin, bif.HIin};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input int ra, input int rb,
                                          input int rc);
        logic [14:0] junk;
        junk = 15'($urandom);
        return {opc, 4'(ra), 4'(rb), 4'(rc), junk};
    endfunction

    task automatic push_instr(input logic [4:0] opc, input int ra, input int rb, input int rc,
                              input int stall);
        logic [15:0] ra_oh, rb_oh, rc_oh;
        bit unary, long_op, halt;
        ra_oh   = 16'd1 << ra;
        rb_oh   = 16'd1 << rb;
        rc_oh   = 16'd1 << rc;
        unary   = (opc == 5'b10001) || (opc == 5'b10010);
        long_op = (opc == 5'b01111) || (opc == 5'b10000);
        halt    = (opc == 5'b11011);
        exp_q.push_back(mk(4'd1, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 16'd0, 16'd0, 5'd0, 1'b0));
        for (int k = 0; k <= stall; k++)
            exp_q.push_back(mk(4'd2, S_ZLOWOUT | S_READ | S_MDRIN | ((k == 0) ? S_PCIN : 15'd0),
                               16'd0, 16'd0, 5'd0, 1'b0));
        exp_q.push_back(mk(4'd3, S_MDROUT | S_IRIN, 16'd0, 16'd0, 5'd0, 1'b0));
        if (halt || unary)
            exp_q.push_back(mk(4'd4, 15'd0, 16'd0, 16'd0, 5'd0, 1'b0));
        else
            exp_q.push_back(mk(4'd4, S_YIN, rb_oh, 16'd0, 5'd0, 1'b0));
        if (!halt) begin
            exp_q.push_back(mk(4'd5, S_ZLOWIN | S_ZHIGHIN, unary ? rb_oh : rc_oh, 16'd0, opc, 1'b0));
            if (long_op) begin
                exp_q.push_back(mk(4'd6, S_ZLOWOUT | S_LOIN, 16'd0, 16'd0, 5'd0, 1'b0));
                exp_q.push_back(mk(4'd7, S_ZHIGHOUT | S_HIIN, 16'd0, 16'd0, 5'd0, 1'b1));
            end else begin
                exp_q.push_back(mk(4'd6, S_ZLOWOUT, 16'd0, ra_oh, 5'd0, 1'b1));
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic start_instr(input int stall);
        bif.Run       = 1'b1;
        bif.mem_ready = (stall == 0);
    endtask

    // Observe cycle i of an n-cycle instruction, then set inputs for the next edge.
    task automatic step(input int i, input int n, input int stall, input logic [31:0] ir,
                        input logic run_mid, input logic run_last, output logic [OBS_W-1:0] obs);
        @(negedge Clock);
        obs = sample();
        if (i == 2 + stall) bif.IR = ir;
        bif.mem_ready = (i > stall);
        bif.Run       = (i == n - 1) ? run_last : run_mid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [OBS_W-1:0] obs;
        #2;
        obs = sample();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_during: got %h required %h", obs, {OBS_W{1'b0}});
        end
        @(negedge Clock);
        clear = 1'b0;
        @(negedge Clock);
        obs = sample();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_after: got %h required %h", obs, {OBS_W{1'b0}});
        end
    endtask

    task automatic test_single(input string name, input logic [4:0] opc, input int ra,
                               input int rb, input int rc, input int stall, input logic run_mid);
        logic [OBS_W-1:0] obs, exp;
        logic [31:0] ir;
        int n;
        ir = mk_ir(opc, ra, rb, rc);
        push_instr(opc, ra, rb, rc, stall);
        n = exp_q.size();
        start_instr(stall);
        for (int i = 0; i < n; i++) begin
            step(i, n, stall, ir, run_mid, 1'b0, obs);
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s cycle %0d of %0d: got %h required %h", name, i, n, obs, exp);
            end
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge Clock);
            obs = sample();
            n_cmp++;
            if (obs !== '0) begin
                n_err++;
                $display("FAIL %s idle_after %0d: got %h required %h", name, j, obs, {OBS_W{1'b0}});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OBS_W-1:0] obs, exp;
        logic [31:0] ir;
        logic [4:0] tbl [4] = '{5'b10010, 5'b10000, 5'b00101, 5'b01111};
        logic [4:0] opc;
        int ra, rb, rc, stall, n;
        for (int k = 0; k < 7; k++) begin
            opc = (k < 4) ? tbl[k] : 5'($urandom_range(0, 31));
            if (opc == 5'b11011) opc = 5'b00000;
            ra    = $urandom_range(0, 15);
            rb    = $urandom_range(0, 15);
            rc    = $urandom_range(0, 15);
            stall = $urandom_range(0, 2);
            ir    = mk_ir(opc, ra, rb, rc);
            push_instr(opc, ra, rb, rc, stall);
            n = exp_q.size();
            start_instr(stall);
            for (int i = 0; i < n; i++) begin
                step(i, n, stall, ir, 1'b1, (k != 6), obs);
                exp = exp_q.pop_front();
                n_cmp++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL b2b instr %0d op %b cycle %0d: got %h required %h",
                             k, opc, i, obs, exp);
                end
            end
        end
        @(negedge Clock);
        obs = sample();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL b2b idle_after: got %h required %h", obs, {OBS_W{1'b0}});
        end
    endtask

    task automatic test_clear_mid();
        logic [OBS_W-1:0] obs, exp;
        logic [31:0] ir;
        ir = mk_ir(5'b00011, 3, 1, 2);
        push_instr(5'b00011, 3, 1, 2, 0);
        start_instr(0);
        for (int i = 0; i < 4; i++) begin
            step(i, 6, 0, ir, 1'b1, 1'b1, obs);
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL clear_pre cycle %0d: got %h required %h", i, obs, exp);
            end
        end
        @(posedge Clock);
        #2;
        obs = sample();
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL clear_ex4: got %h required %h", obs, exp);
        end
        exp_q.delete();
        clear = 1'b1;
        #1;
        obs = sample();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL clear_async: got %h required %h", obs, {OBS_W{1'b0}});
        end
        @(negedge Clock);
        obs = sample();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL clear_held: got %h required %h", obs, {OBS_W{1'b0}});
        end
        clear = 1'b0;
        test_single("clear_restart", 5'b00011, 3, 1, 2, 0, 1'b1);
    endtask

    task automatic test_halt();
        logic [OBS_W-1:0] obs, exp;
        logic [31:0] ir;
        int n;
        ir = mk_ir(5'b11011, 2, 4, 6);
        push_instr(5'b11011, 2, 4, 6, 0);
        n = exp_q.size();
        start_instr(0);
        for (int i = 0; i < n; i++) begin
            step(i, n, 0, ir, 1'b1, 1'b1, obs);
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL halt_fetch cycle %0d: got %h required %h", i, obs, exp);
            end
        end
        for (int j = 0; j < 10; j++) exp_q.push_back(mk(4'd8, 15'd0, 16'd0, 16'd0, 5'd0, 1'b0));
        for (int j = 0; j < 10; j++) begin
            @(negedge Clock);
            obs = sample();
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL halt_hold cycle %0d: got %h required %h", j, obs, exp);
            end
        end
        bif.Run = 1'b0;
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0;
        @(negedge Clock);
        obs = sample();
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL halt_cleared: got %h required %h", obs, {OBS_W{1'b0}});
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear         = 1'b1;
        bif.Run       = 1'b0;
        bif.mem_ready = 1'b0;
        bif.IR        = '0;
        test_reset();
        test_single("neg", 5'b10001, 5, 0, 0, 0, 1'b1);
        test_single("add", 5'b00011, 3, 1, 2, 0, 1'b1);
        test_single("mul", 5'b01111, 0, 1, 2, 0, 1'b1);
        test_single("stall", 5'b10001, 5, 0, 0, 3, 1'b1);
        test_single("run_drop", 5'b00111, 7, 4, 9, 1, 1'b0);
        test_back_to_back();
        test_clear_mid();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
